ascii_ps2_sender: RTL
=====================

# ascii_ps2_sender

Converts ASCII characters into PS/2 keyboard scan-code traffic and drives it onto a PS/2 clock/data pair, acting as the device side of the link. For every accepted character it emits a make code, then the break prefix F0 and the make code again, each as an 11-bit PS/2 frame. It sits beside the keyboard receive path. It is used for loopback tests of the scan-code-to-ASCII translator and for emulating a keyboard toward an external host.

## Interface
Parameters:
- HALF_PERIOD, 2000: CLK_50 cycles per PS/2 clock half-period (12.5 kHz at 50 MHz); minimum 2.
- GAP_CYCLES, 4000: idle CLK_50 cycles, with both lines released, between frames.
- ROM_FILE, "SCANCODE.txt": $readmemh image of 128 × 9-bit entries; bit 8 = shift required, bits 7:0 = make code (00 = unsupported).

Ports:
- CLK_50  in  1  system clock; the block has one clock and everything is synchronous to it.
- RST_N  in  1  asynchronous, active-low reset.
- in_en  in  1  character valid; sampled only when busy=0.
- ASCII  in  8  character to send.
- busy  out  1  high from the cycle after acceptance until the last frame's gap completes.
- err  out  1  one-cycle pulse when a character is rejected.
- ps2_clk_i  in  1  sensed PS/2 clock line; the block passes it through a 2-flop synchronizer.
- ps2_clk_o  out  1  PS/2 clock drive; 1 = released, 0 = pull low.
- ps2_data_o  out  1  PS/2 data drive; 1 = released, 0 = pull low.

## Operation
- Reset values: busy=0, err=0, ps2_clk_o=1, ps2_data_o=1. The sequencer is in IDLE and all counters are 0.
- Accept: a character is accepted when in_en=1, busy=0 and the block is in IDLE. ASCII is latched.
- Reject: if ASCII[7]=1 or the ROM code is 00, the block pulses err, busy stays 0 and nothing is sent.
- Byte sequence (SEQ state): M, F0, M, where M is the ROM make code.
- Sequencer states: IDLE → LOOKUP → SEND(byte index) → GAP → next SEND or IDLE.
- Frame serializer states: WAIT_HI → BIT_HI → BIT_LO → STOP → DONE.
- Frame bits, in order:
  - start bit 0;
  - data bits D0..D7, LSB first;
  - odd parity bit (the XOR of the data bits, inverted);
  - stop bit 1.
- Per bit:
  - ps2_data_o is updated on the first cycle of the clock-high half-period.
  - ps2_clk_o is held 1 for HALF_PERIOD cycles, then 0 for HALF_PERIOD cycles.
- After the stop bit's low phase, both lines are released for GAP_CYCLES.
- Frame start condition: a frame starts only when the synchronized ps2_clk_i has read 1 for GAP_CYCLES consecutive cycles (WAIT_HI).
- Host inhibit: if the synchronized ps2_clk_i reads 0 while ps2_clk_o=1 during any bit of a frame, the block:
  - aborts the frame;
  - releases both lines;
  - returns to WAIT_HI;
  - resends the same byte from its start bit. Bytes already completed are not resent.
- In IDLE, inhibit has no effect; acceptance is still allowed.
- in_en while busy=1 is ignored; there is no queue.
- Reset asserted mid-frame immediately releases both lines and drops busy. The partial frame is abandoned.

## Timing
- Lookup latency: the ROM read is registered, so LOOKUP takes one cycle.
- Rejected character: err is high exactly on the second cycle after acceptance.
- Accepted character: busy=1 from the cycle after acceptance.
- The first start bit appears on ps2_data_o no earlier than GAP_CYCLES+2 cycles after acceptance.
- One frame lasts 22·HALF_PERIOD cycles, plus the GAP_CYCLES gap.
- busy falls after the final gap; a new character can be accepted on the cycle busy reads 0.
- Inhibit detection latency is 2 cycles (synchronizer). The abort takes effect on the next edge after detection.

## Configuration
- SHIFT_SEQ_EN defined:
  - Entries with bit 8 set are sent as 12, M, F0, M, F0, 12 (six frames; left-shift make/break around the key).
  - Entries without bit 8 set are sent as 3 frames.
- SHIFT_SEQ_EN undefined: bit 8 is ignored and every character is sent as 3 frames (for example, 'A' is sent as the 'a' key).

## Structure
- ps2_pkg holds:
  - constants BREAK_CODE=8'hF0, LSHIFT_CODE=8'h12, FRAME_BITS=11;
  - the sequencer and serializer state enums.
- Sub-module ps2_frame_tx serializes one byte. Its ports are:
  - start/byte_in/done handshake;
  - ps2_clk_i_sync input;
  - ps2_clk_o and ps2_data_o outputs;
  - the HALF_PERIOD/GAP_CYCLES counters and the inhibit abort/retry logic.
- The top level holds the ROM, the byte-sequence FSM and the err/busy logic.

## Test plan
Bench settings: HALF_PERIOD=4, GAP_CYCLES=8, ps2_clk_i tied to ps2_clk_o unless stated.

- 'a' (8'h61, ROM 0_1C) → frames 1C, F0, 1C. The first frame's bits are 0,0,0,1,1,1,0,0,0,0,1. Each frame lasts 88 cycles. busy then falls.
- 8'h80, and a character whose ROM entry is 000 → err pulses for one cycle on cycle 2, busy is never asserted, and both lines stay released.
- 'A' (ROM 1_1C) with SHIFT_SEQ_EN → frames 12, 1C, F0, 1C, F0, 12. Without the macro → frames 1C, F0, 1C.
- Host forces ps2_clk_i low during bit 5 of the second frame (F0) → the line is released within 3 cycles. After ps2_clk_i is high for 8 cycles, F0 is resent in full and 1C follows. The first 1C is not resent.
- in_en pulsed with 'b' while busy=1 → ignored; only the first character's frames appear.
- RST_N asserted at bit 3 of the first frame → ps2_clk_o=1, ps2_data_o=1 and busy=0 asynchronously. A new 'a' after release sends a full, correct sequence.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared constants, state encodings and the ASCII-to-scan-code table for the PS/2 sender.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// The scan-code table is compiled in: bit 8 = shift required, bits 7:0 = set-2 make code, 00 = unsupported.
package ps2_pkg;

    localparam logic [7:0] BREAK_CODE  = 8'hF0;
    localparam logic [7:0] LSHIFT_CODE = 8'h12;
    localparam int         FRAME_BITS  = 11;

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_LOOKUP,
        SEQ_SEND,
        SEQ_GAP
    } seq_state_t;

    typedef enum logic [2:0] {
        TX_WAIT_HI,
        TX_BIT_HI,
        TX_BIT_LO,
        TX_STOP,
        TX_DONE
    } tx_state_t;

    // Upper-case letters share the lower-case key and request shift.
    function automatic logic [8:0] scan_lookup(input logic [6:0] c);
        logic [6:0] k;
        logic       sh;
        logic [7:0] m;
        sh = 1'b0;
        k  = c;
        if (c >= 7'h41 && c <= 7'h5A) begin
            sh = 1'b1;
            k  = c | 7'h20;
        end
        case (k)
            7'h61: m = 8'h1C;  7'h62: m = 8'h32;  7'h63: m = 8'h21;  7'h64: m = 8'h23;
            7'h65: m = 8'h24;  7'h66: m = 8'h2B;  7'h67: m = 8'h34;  7'h68: m = 8'h33;
            7'h69: m = 8'h43;  7'h6A: m = 8'h3B;  7'h6B: m = 8'h42;  7'h6C: m = 8'h4B;
            7'h6D: m = 8'h3A;  7'h6E: m = 8'h31;  7'h6F: m = 8'h44;  7'h70: m = 8'h4D;
            7'h71: m = 8'h15;  7'h72: m = 8'h2D;  7'h73: m = 8'h1B;  7'h74: m = 8'h2C;
            7'h75: m = 8'h3C;  7'h76: m = 8'h2A;  7'h77: m = 8'h1D;  7'h78: m = 8'h22;
            7'h79: m = 8'h35;  7'h7A: m = 8'h1A;
            7'h30: m = 8'h45;  7'h31: m = 8'h16;  7'h32: m = 8'h1E;  7'h33: m = 8'h26;
            7'h34: m = 8'h25;  7'h35: m = 8'h2E;  7'h36: m = 8'h36;  7'h37: m = 8'h3D;
            7'h38: m = 8'h3E;  7'h39: m = 8'h46;
            7'h20: m = 8'h29;  7'h0D: m = 8'h5A;  7'h08: m = 8'h66;  7'h09: m = 8'h0D;
            7'h2D: m = 8'h4E;  7'h3D: m = 8'h55;  7'h2C: m = 8'h41;  7'h2E: m = 8'h49;
            7'h2F: m = 8'h4A;  7'h3B: m = 8'h4C;  7'h27: m = 8'h52;  7'h5B: m = 8'h54;
            7'h5D: m = 8'h5B;  7'h5C: m = 8'h5D;  7'h60: m = 8'h0E;
            default: m = 8'h00;
        endcase
        return {sh, m};
    endfunction

    // Byte idx of the make/break sequence for one key.
    function automatic logic [7:0] seq_byte(input logic [2:0] idx, input logic [7:0] make,
                                            input logic shift);
        logic [7:0] b;
        b = make;
        if (shift) begin
            case (idx)
                3'd0, 3'd5: b = LSHIFT_CODE;
                3'd2, 3'd4: b = BREAK_CODE;
                default:    b = make;
            endcase
        end else if (idx == 3'd1) begin
            b = BREAK_CODE;
        end
        return b;
    endfunction

endpackage

// File: rtl/ps2_frame_tx.sv
// Serializes one byte as an 11-bit PS/2 device frame (start, D0..D7, odd parity, stop).
// Latency: GAP_CYCLES of sensed-high clock, 22*HALF_PERIOD frame, GAP_CYCLES release, then done pulses.
// Backpressure: host inhibit (clock sensed low while driven high) aborts and resends the byte.
// Ports: CLK_50/RST_N; start+byte_in launch a frame in TX_DONE; done pulses one cycle at the end;
//        ps2_clk_i_sync is the synchronized sensed clock; ps2_clk_o/ps2_data_o are open-drain drives (1 = released).
module ps2_frame_tx
    import ps2_pkg::*;
#(
    parameter int HALF_PERIOD = 2000,
    parameter int GAP_CYCLES  = 4000
) (
    input  logic       CLK_50,
    input  logic       RST_N,
    input  logic       start,
    input  logic [7:0] byte_in,
    input  logic       ps2_clk_i_sync,
    output logic       done,
    output logic       ps2_clk_o,
    output logic       ps2_data_o
);

    localparam int CNT_MAX = (HALF_PERIOD > GAP_CYCLES) ? HALF_PERIOD : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] HP_LAST  = CNT_W'(HALF_PERIOD - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
    localparam logic [3:0]       BIT_LAST = 4'(FRAME_BITS - 1);

    tx_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_bitidx;
    logic [10:0]      r_frame;
    logic             r_clk_o;
    logic             r_data_o;
    logic             r_done;
    logic             r_clk_d1;
    logic             r_clk_d2;
    logic             w_inhibit;

    // The sensed clock lags our own drive by the two synchronizer flops, so compare
    // against the drive delayed by two cycles; otherwise our own low phase looks like an inhibit.
    assign w_inhibit = r_clk_d2 && !ps2_clk_i_sync;

    always_ff @(posedge CLK_50 or negedge RST_N) begin
        if (!RST_N) begin
            r_state  <= TX_DONE;
            r_cnt    <= '0;
            r_bitidx <= '0;
            r_frame  <= '1;
            r_clk_o  <= 1'b1;
            r_data_o <= 1'b1;
            r_done   <= 1'b0;
            r_clk_d1 <= 1'b1;
            r_clk_d2 <= 1'b1;
        end else begin
            r_done   <= 1'b0;
            r_clk_d1 <= r_clk_o;
            r_clk_d2 <= r_clk_d1;
            case (r_state)
                TX_DONE: begin
                    if (start) begin
                        r_frame <= {1'b1, ~^byte_in, byte_in, 1'b0};
                        r_cnt   <= '0;
                        r_state <= TX_WAIT_HI;
                    end
                end
                TX_WAIT_HI: begin
                    if (!ps2_clk_i_sync) begin
                        r_cnt <= '0;
                    end else if (r_cnt == GAP_LAST) begin
                        r_cnt    <= '0;
                        r_bitidx <= '0;
                        r_data_o <= r_frame[0];
                        r_state  <= TX_BIT_HI;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                TX_BIT_HI, TX_BIT_LO: begin
                    if (w_inhibit) begin
                        // Abandon the partial frame; the whole byte goes again from its start bit.
                        r_cnt    <= '0;
                        r_bitidx <= '0;
                        r_clk_o  <= 1'b1;
                        r_data_o <= 1'b1;
                        r_state  <= TX_WAIT_HI;
                    end else if (r_cnt != HP_LAST) begin
                        r_cnt <= r_cnt + 1'b1;
                    end else if (r_state == TX_BIT_HI) begin
                        r_cnt   <= '0;
                        r_clk_o <= 1'b0;
                        r_state <= TX_BIT_LO;
                    end else begin
                        r_cnt   <= '0;
                        r_clk_o <= 1'b1;
                        if (r_bitidx == BIT_LAST) begin
                            r_data_o <= 1'b1;
                            r_state  <= TX_STOP;
                        end else begin
                            r_bitidx <= r_bitidx + 4'd1;
                            r_data_o <= r_frame[r_bitidx + 4'd1];
                            r_state  <= TX_BIT_HI;
                        end
                    end
                end
                TX_STOP: begin
                    if (r_cnt == GAP_LAST) begin
                        r_cnt   <= '0;
                        r_done  <= 1'b1;
                        r_state <= TX_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= TX_DONE;
            endcase
        end
    end

    assign done       = r_done;
    assign ps2_clk_o  = r_clk_o;
    assign ps2_data_o = r_data_o;

endmodule

// File: rtl/ascii_ps2_sender.sv
// Turns an accepted ASCII character into make / F0 / make PS/2 frames driven as a keyboard device.
// Latency: one-cycle registered lookup, err on the 2nd cycle after acceptance, first start bit >= GAP_CYCLES+2 cycles.
// Backpressure: busy blocks new characters (in_en ignored, no queue); host inhibit delays and resends frames.
// Ports: CLK_50/RST_N; in_en+ASCII character input; busy/err status; ps2_clk_i sensed clock;
//        ps2_clk_o/ps2_data_o open-drain drives (1 = released).
// Build option SHIFT_SEQ_EN: shifted keys are wrapped in left-shift make/break (6 frames).
module ascii_ps2_sender
    import ps2_pkg::*;
#(
    parameter int HALF_PERIOD = 2000,
    parameter int GAP_CYCLES  = 4000
) (
    input  logic       CLK_50,
    input  logic       RST_N,
    input  logic       in_en,
    input  logic [7:0] ASCII,
    output logic       busy,
    output logic       err,
    input  logic       ps2_clk_i,
    output logic       ps2_clk_o,
    output logic       ps2_data_o
);

    seq_state_t r_state;
    logic [7:0] r_make;
    logic       r_shift;
    logic       r_ok;
    logic [2:0] r_idx;
    logic       r_busy;
    logic       r_err;
    logic       r_start;
    logic [7:0] r_byte;
    logic       r_sync1;
    logic       r_sync2;

    logic [7:0] w_make;
    logic       w_shift;
    logic       w_ok;
    logic [2:0] w_last;
    logic       w_done;

`ifdef SHIFT_SEQ_EN
    logic [8:0] w_entry;
    assign w_entry = scan_lookup(ASCII[6:0]);
    assign w_make  = w_entry[7:0];
    assign w_shift = w_entry[8];
`else
    assign w_make  = 8'(scan_lookup(ASCII[6:0]));
    assign w_shift = 1'b0;
`endif

    // Rejection is known at acceptance, so busy never rises for a rejected character.
    assign w_ok   = !ASCII[7] && (w_make != 8'h00);
    assign w_last = r_shift ? 3'd5 : 3'd2;

    always_ff @(posedge CLK_50 or negedge RST_N) begin
        if (!RST_N) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= ps2_clk_i;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge CLK_50 or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= SEQ_IDLE;
            r_make  <= '0;
            r_shift <= 1'b0;
            r_ok    <= 1'b0;
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
            r_start <= 1'b0;
            r_byte  <= '0;
        end else begin
            r_err   <= 1'b0;
            r_start <= 1'b0;
            case (r_state)
                SEQ_IDLE: begin
                    if (in_en && !r_busy) begin
                        r_make  <= w_make;
                        r_shift <= w_shift;
                        r_ok    <= w_ok;
                        r_busy  <= w_ok;
                        r_idx   <= '0;
                        r_state <= SEQ_LOOKUP;
                    end
                end
                SEQ_LOOKUP: begin
                    if (!r_ok) begin
                        r_err   <= 1'b1;
                        r_state <= SEQ_IDLE;
                    end else begin
                        r_start <= 1'b1;
                        r_byte  <= seq_byte(3'd0, r_make, r_shift);
                        r_state <= SEQ_SEND;
                    end
                end
                SEQ_SEND: r_state <= SEQ_GAP;
                SEQ_GAP: begin
                    if (w_done) begin
                        if (r_idx == w_last) begin
                            r_busy  <= 1'b0;
                            r_state <= SEQ_IDLE;
                        end else begin
                            r_idx   <= r_idx + 3'd1;
                            r_start <= 1'b1;
                            r_byte  <= seq_byte(r_idx + 3'd1, r_make, r_shift);
                            r_state <= SEQ_SEND;
                        end
                    end
                end
                default: r_state <= SEQ_IDLE;
            endcase
        end
    end

    ps2_frame_tx #(
        .HALF_PERIOD (HALF_PERIOD),
        .GAP_CYCLES  (GAP_CYCLES)
    ) u_frame_tx (
        .CLK_50         (CLK_50),
        .RST_N          (RST_N),
        .start          (r_start),
        .byte_in        (r_byte),
        .ps2_clk_i_sync (r_sync2),
        .done           (w_done),
        .ps2_clk_o      (ps2_clk_o),
        .ps2_data_o     (ps2_data_o)
    );

    assign busy = r_busy;
    assign err  = r_err;

endmodule
